// File: rtl/tempo_pkg.sv
// ============================================================================
// Module   : tempo_pkg
// Purpose  : Shared FSM encoding, step sizes and repeat-interval helper for
//            the tempo controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tempo_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_HOLD_UP   = 2'd1;
    localparam logic [1:0] ST_HOLD_DN   = 2'd2;
    localparam logic [1:0] ST_HOLD_BOTH = 2'd3;

    localparam int STEP_SMALL = 1;
    localparam int STEP_LARGE = 5;

    // Divide first so large clock rates cannot overflow a 32-bit product.
    function automatic int repeat_cycles(input int clk_freq_hz, input int repeat_ms);
        return (clk_freq_hz / 1000) * repeat_ms;
    endfunction

endpackage

`default_nettype wire

// File: rtl/repeat_timer.sv
// ============================================================================
// Module   : repeat_timer
// Purpose  : Free-running interval counter with synchronous clear, enable and
//            a one-cycle terminal-count tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module repeat_timer #(
    parameter int CYCLES = 7500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int                 c_CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_terminal;

    assign w_terminal = (r_count == c_LAST);

    // A clear in the same cycle means the interval is being restarted, so the
    // pending terminal count must not escape as a tick.
    assign o_tick = i_enable & ~i_clear & w_terminal;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_terminal ? '0 : (r_count + c_ONE);
        end
    end

endmodule

`default_nettype wire

// File: rtl/tempo_controller.sv
// ============================================================================
// Module   : tempo_controller
// Purpose  : Owns the metronome BPM register: sums button steps and auto-repeat
//            ticks, then clamps (or wraps when TEMPO_WRAP_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tempo_controller
    import tempo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BPM_W       = 9,
    parameter int BPM_MIN     = 30,
    parameter int BPM_MAX     = 300,
    parameter int BPM_DEFAULT = 120,
    parameter int REPEAT_MS   = 150
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_btn_reset,
    input  logic             i_plus_1,
    input  logic             i_plus_5,
    input  logic             i_plus_5_hold,
    input  logic             i_minus_1,
    input  logic             i_minus_5,
    input  logic             i_minus_5_hold,
    output logic [BPM_W-1:0] o_bpm,
    output logic             o_bpm_changed,
    output logic             o_at_min,
    output logic             o_at_max
);

    localparam int c_REPEAT_CYCLES = repeat_cycles(CLK_FREQ_HZ, REPEAT_MS);
    localparam int c_SUM_W         = BPM_W + 2;

    localparam logic signed [c_SUM_W-1:0] c_MIN_S   = c_SUM_W'(BPM_MIN);
    localparam logic signed [c_SUM_W-1:0] c_MAX_S   = c_SUM_W'(BPM_MAX);
    localparam logic signed [c_SUM_W-1:0] c_SMALL_S = c_SUM_W'(STEP_SMALL);
    localparam logic signed [c_SUM_W-1:0] c_LARGE_S = c_SUM_W'(STEP_LARGE);
`ifdef TEMPO_WRAP_EN
    localparam logic signed [c_SUM_W-1:0] c_ONE_S   = c_SUM_W'(1);
`endif

    localparam logic [BPM_W-1:0] c_MIN     = BPM_W'(BPM_MIN);
    localparam logic [BPM_W-1:0] c_MAX     = BPM_W'(BPM_MAX);
    localparam logic [BPM_W-1:0] c_DEFAULT = BPM_W'(BPM_DEFAULT);

    logic [1:0]                r_state;
    logic [1:0]                w_state_next;
    logic [BPM_W-1:0]          r_bpm;
    logic                      r_changed;
    logic [BPM_W-1:0]          w_bpm_next;
    logic signed [c_SUM_W-1:0] w_delta;
    logic signed [c_SUM_W-1:0] w_sum;
    logic                      w_tick;
    logic                      w_clear;
    logic                      w_enable;
    logic                      w_rep_up;
    logic                      w_rep_dn;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The hold levels alone determine the target state; soft reset overrides.
    always_comb begin
        w_state_next = r_state;
        if (i_btn_reset) begin
            w_state_next = ST_IDLE;
        end else begin
            case ({i_plus_5_hold, i_minus_5_hold})
                2'b11:   w_state_next = ST_HOLD_BOTH;
                2'b10:   w_state_next = ST_HOLD_UP;
                2'b01:   w_state_next = ST_HOLD_DN;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_enable = (r_state == ST_HOLD_UP) | (r_state == ST_HOLD_DN);
    assign w_clear  = i_btn_reset | (w_state_next != r_state);
    assign w_rep_up = w_tick & (r_state == ST_HOLD_UP);
    assign w_rep_dn = w_tick & (r_state == ST_HOLD_DN);

    repeat_timer #(
        .CYCLES (c_REPEAT_CYCLES)
    ) u_repeat_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_delta = '0;
        if (i_plus_1)  w_delta = w_delta + c_SMALL_S;
        if (i_plus_5)  w_delta = w_delta + c_LARGE_S;
        if (w_rep_up)  w_delta = w_delta + c_LARGE_S;
        if (i_minus_1) w_delta = w_delta - c_SMALL_S;
        if (i_minus_5) w_delta = w_delta - c_LARGE_S;
        if (w_rep_dn)  w_delta = w_delta - c_LARGE_S;
    end

    assign w_sum = $signed({2'b00, r_bpm}) + w_delta;

    always_comb begin
        w_bpm_next = BPM_W'(w_sum);
        if (i_btn_reset) begin
            w_bpm_next = c_DEFAULT;
        end else if (w_sum > c_MAX_S) begin
`ifdef TEMPO_WRAP_EN
            w_bpm_next = BPM_W'(w_sum - c_MAX_S - c_ONE_S + c_MIN_S);
`else
            w_bpm_next = c_MAX;
`endif
        end else if (w_sum < c_MIN_S) begin
`ifdef TEMPO_WRAP_EN
            w_bpm_next = BPM_W'(c_MAX_S - c_MIN_S + w_sum + c_ONE_S);
`else
            w_bpm_next = c_MIN;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bpm     <= c_DEFAULT;
            r_changed <= 1'b0;
        end else begin
            r_bpm     <= w_bpm_next;
            r_changed <= (w_bpm_next != r_bpm);
        end
    end

    assign o_bpm         = r_bpm;
    assign o_bpm_changed = r_changed;
    assign o_at_min      = (r_bpm == c_MIN);
    assign o_at_max      = (r_bpm == c_MAX);

endmodule

`default_nettype wire

// File: tb/tb_tempo_controller.sv
// ============================================================================
// Module   : tb_tempo_controller
// Purpose  : Directed and randomized checks of tempo_controller against an
//            elapsed-time tempo model through an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tempo_controller;

    localparam int BPM_W = 9;
    localparam int RPT   = 10;

    logic             i_clk = 1'b0;
    logic             i_reset = 1'b1;
    logic             i_btn_reset = 1'b0;
    logic             i_plus_1 = 1'b0;
    logic             i_plus_5 = 1'b0;
    logic             i_plus_5_hold = 1'b0;
    logic             i_minus_1 = 1'b0;
    logic             i_minus_5 = 1'b0;
    logic             i_minus_5_hold = 1'b0;
    logic [BPM_W-1:0] o_bpm;
    logic             o_bpm_changed;
    logic             o_at_min;
    logic             o_at_max;

    always #5 i_clk = ~i_clk;

    tempo_controller #(
        .CLK_FREQ_HZ (10000),
        .BPM_W       (BPM_W),
        .BPM_MIN     (30),
        .BPM_MAX     (300),
        .BPM_DEFAULT (120),
        .REPEAT_MS   (1)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_btn_reset    (i_btn_reset),
        .i_plus_1       (i_plus_1),
        .i_plus_5       (i_plus_5),
        .i_plus_5_hold  (i_plus_5_hold),
        .i_minus_1      (i_minus_1),
        .i_minus_5      (i_minus_5),
        .i_minus_5_hold (i_minus_5_hold),
        .o_bpm          (o_bpm),
        .o_bpm_changed  (o_bpm_changed),
        .o_at_min       (o_at_min),
        .o_at_max       (o_at_max)
    );

    typedef struct packed {
        logic [BPM_W-1:0] bpm;
        logic             changed;
        logic             at_min;
        logic             at_max;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference state: tempo, hold mode (0 none, 1 up, 2 down, 3 both) and
    // cycles elapsed since the current hold mode began.
    int   m_bpm     = 120;
    int   m_mode    = 0;
    int   m_elapsed = 0;
    logic hold_p    = 1'b0;
    logic hold_m    = 1'b0;

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int fix_range(input int v);
`ifdef TEMPO_WRAP_EN
        if (v > 300) return 30 + (v - 300 - 1);
        if (v < 30)  return 300 - (30 - v - 1);
        return v;
`else
        if (v > 300) return 300;
        if (v < 30)  return 30;
        return v;
`endif
    endfunction

    task automatic model_push(input logic p1, input logic p5, input logic m1,
                              input logic m5, input logic ph, input logic mh,
                              input logic br);
        int   lv;
        int   nb;
        int   delta;
        bit   rep;
        exp_t e;
        lv = (ph && mh) ? 3 : ph ? 1 : mh ? 2 : 0;
        if (br) begin
            nb        = 120;
            m_mode    = 0;
            m_elapsed = 0;
        end else begin
            rep   = (m_mode == 1 || m_mode == 2) && (lv == m_mode) && (m_elapsed == RPT - 1);
            delta = int'(p1) + 5 * int'(p5) - int'(m1) - 5 * int'(m5);
            if (rep) delta += (m_mode == 1) ? 5 : -5;
            nb = fix_range(m_bpm + delta);
            if (lv != m_mode) begin
                m_mode    = lv;
                m_elapsed = 0;
            end else if (m_mode == 1 || m_mode == 2) begin
                m_elapsed = (m_elapsed + 1) % RPT;
            end
        end
        e.bpm     = BPM_W'(nb);
        e.changed = (nb != m_bpm);
        e.at_min  = (nb == 30);
        e.at_max  = (nb == 300);
        m_bpm     = nb;
        q.push_back(e);
    endtask

    task automatic cyc(input logic p1, input logic p5, input logic m1,
                       input logic m5, input logic br);
        @(negedge i_clk);
        i_plus_1       = p1;
        i_plus_5       = p5;
        i_minus_1      = m1;
        i_minus_5      = m5;
        i_btn_reset    = br;
        i_plus_5_hold  = hold_p;
        i_minus_5_hold = hold_m;
        model_push(p1, p5, m1, m5, hold_p, hold_m, br);
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every clock edge with an outstanding expectation is compared.
    always @(posedge i_clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check_val("bpm",     int'(o_bpm),         int'(mon_e.bpm));
            check_val("changed", int'(o_bpm_changed), int'(mon_e.changed));
            check_val("at_min",  int'(o_at_min),      int'(mon_e.at_min));
            check_val("at_max",  int'(o_at_max),      int'(mon_e.at_max));
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        check_val("reset_bpm",     int'(o_bpm),         120);
        check_val("reset_changed", int'(o_bpm_changed), 0);
        check_val("reset_at_min",  int'(o_at_min),      0);
        check_val("reset_at_max",  int'(o_at_max),      0);

        // Single steps on separate cycles.
        cyc(1, 0, 0, 0, 0); check_val("seq_plus1",  int'(o_bpm), 121);
        cyc(0, 1, 0, 0, 0); check_val("seq_plus5",  int'(o_bpm), 126);
        cyc(0, 0, 1, 0, 0); check_val("seq_minus1", int'(o_bpm), 125);

        // Simultaneous requests net together.
        cyc(0, 0, 0, 0, 1); check_val("soft_reset", int'(o_bpm), 120);
        cyc(0, 1, 1, 0, 0); check_val("net_p5_m1",  int'(o_bpm), 124);
        cyc(1, 0, 1, 0, 0); check_val("net_zero_strobe", int'(o_bpm_changed), 0);

        // Walk up to 298 and cross the top boundary.
        for (int k = 0; k < 34; k++) cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++)  cyc(1, 0, 0, 0, 0);
        check_val("at_298", int'(o_bpm), 298);
        cyc(0, 1, 0, 0, 0);
`ifdef TEMPO_WRAP_EN
        check_val("top_wrap", int'(o_bpm), 32);
`else
        check_val("top_clamp",  int'(o_bpm),    300);
        check_val("top_at_max", int'(o_at_max), 1);
        cyc(0, 1, 0, 0, 0);
        check_val("top_hold_value",  int'(o_bpm),         300);
        check_val("top_hold_strobe", int'(o_bpm_changed), 0);
`endif

        // Auto-repeat downward from 120.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0); check_val("hold_first", int'(o_bpm), 115);
        hold_m = 1'b1;
        idle(10); check_val("hold_before_rep", int'(o_bpm), 115);
        idle(1);  check_val("hold_rep1",       int'(o_bpm), 110);
        idle(24); check_val("hold_after_35",   int'(o_bpm), 100);
        hold_p = 1'b1;
        idle(15); check_val("hold_both_stops", int'(o_bpm), 100);
        hold_p = 1'b0;
        hold_m = 1'b0;
        idle(2);

        // Soft reset in the middle of an up-hold at 200.
        for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 0);
        check_val("at_200", int'(o_bpm), 200);
        hold_p = 1'b1;
        idle(5);
        cyc(1, 0, 0, 0, 1); check_val("softrst_hold", int'(o_bpm), 120);
        idle(10); check_val("softrst_no_early_rep", int'(o_bpm), 120);
        idle(1);  check_val("softrst_full_interval", int'(o_bpm), 125);
        hold_p = 1'b0;
        idle(2);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 39) == 0) hold_p = ~hold_p;
            if ($urandom_range(0, 39) == 0) hold_m = ~hold_m;
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 199) == 0));
        end
        hold_p = 1'b0;
        hold_m = 1'b0;
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0);

        // Asynchronous reset mid-operation takes effect without a clock edge.
        @(negedge i_clk);
        i_plus_1 = 1'b0; i_plus_5 = 1'b0; i_minus_1 = 1'b0; i_minus_5 = 1'b0;
        i_btn_reset = 1'b0; i_plus_5_hold = 1'b0; i_minus_5_hold = 1'b0;
        i_reset = 1'b1;
        m_bpm = 120; m_mode = 0; m_elapsed = 0;
        q.push_back('{bpm: BPM_W'(120), changed: 1'b0, at_min: 1'b0, at_max: 1'b0});
        #1;
        check_val("async_rst_bpm",     int'(o_bpm),         120);
        check_val("async_rst_changed", int'(o_bpm_changed), 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        model_push(0, 0, 0, 0, 0, 0, 0);
        @(posedge i_clk);
        #2;
        cyc(1, 0, 0, 0, 0); check_val("post_reset_step", int'(o_bpm), 121);
        idle(2);

        check_val("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tempo_controller.md
Name: tempo_controller

Overview:
- Converts the debounced, single-cycle button events from the input library into the metronome tempo value (BPM).
- Combines simultaneous step requests into one net change and clamps the result to the legal range.
- Sequences auto-repeat of ±5 steps while a hold level is asserted.
- Sits between the button debouncer and the beat generator; it is the single owner of the tempo register.

Parameters:
- CLK_FREQ_HZ, 50000000, i_clk frequency in Hz.
- BPM_W, 9, width of the tempo value.
- BPM_MIN, 30, lowest legal tempo.
- BPM_MAX, 300, highest legal tempo.
- BPM_DEFAULT, 120, tempo after reset or soft reset.
- REPEAT_MS, 150, auto-repeat interval while a hold is active.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_btn_reset  in  1  soft-reset pulse; returns the tempo to BPM_DEFAULT.
- i_plus_1  in  1  one-cycle pulse requesting +1.
- i_plus_5  in  1  one-cycle pulse requesting +5.
- i_plus_5_hold  in  1  level; high while the +5 button is held past the hold threshold.
- i_minus_1  in  1  one-cycle pulse requesting -1.
- i_minus_5  in  1  one-cycle pulse requesting -5.
- i_minus_5_hold  in  1  level; high while the -5 button is held past the hold threshold.
- o_bpm  out  BPM_W  current tempo.
- o_bpm_changed  out  1  one-cycle strobe, high in the cycle o_bpm takes a new value.
- o_at_min  out  1  high while o_bpm == BPM_MIN.
- o_at_max  out  1  high while o_bpm == BPM_MAX.

Behaviour:
- Reset (i_reset high, asynchronous): o_bpm=BPM_DEFAULT, o_bpm_changed=0, FSM=IDLE, repeat counter=0. o_at_min and o_at_max are decoded from o_bpm.
- REPEAT_CYCLES = CLK_FREQ_HZ/1000*REPEAT_MS.
- Net delta, signed BPM_W+2 bits: (+1·i_plus_1) + (+5·i_plus_5) + (+5·rep_up) + (-1·i_minus_1) + (-5·i_minus_5) + (-5·rep_dn). rep_up and rep_dn are internal one-cycle repeat ticks.
- Update:
  - next = o_bpm + delta, clamped to [BPM_MIN, BPM_MAX].
  - Registered; latency is 1 cycle from the request to o_bpm.
  - o_bpm_changed asserts only if next != o_bpm. A zero net delta, or a clamp that leaves the value unchanged, produces no strobe.
- Soft reset: i_btn_reset has top priority in its cycle. o_bpm=BPM_DEFAULT, all step and repeat requests that cycle are ignored, FSM goes to IDLE, counter clears. o_bpm_changed asserts only if the value actually changed.
- FSM states: IDLE, HOLD_UP, HOLD_DN, HOLD_BOTH.
  - IDLE -> HOLD_UP when i_plus_5_hold=1 and i_minus_5_hold=0. IDLE -> HOLD_DN for the mirror case. Either entry clears the counter.
  - Both hold levels high, from any state -> HOLD_BOTH. No repeats are generated in HOLD_BOTH.
  - HOLD_UP / HOLD_DN:
    - The counter increments every cycle.
    - When it reaches REPEAT_CYCLES-1, the matching repeat tick asserts for 1 cycle and the counter wraps to 0.
    - The first repeat therefore occurs REPEAT_CYCLES cycles after entry; the initial +5 comes from the i_plus_5 / i_minus_5 pulse.
  - Any state -> IDLE when both hold levels are low; the counter clears.
  - HOLD_BOTH -> HOLD_UP or HOLD_DN when only one hold level stays high; the counter clears.
- Hold at a boundary: repeats continue to be generated but clamp, so o_bpm does not change and there is no strobe.
- Step pulses and repeat ticks arriving in the same cycle are all summed; none is dropped.

Optional Feature:
- TEMPO_WRAP_EN
  - Defined: out-of-range results wrap instead of clamping.
    - next > BPM_MAX gives BPM_MIN + (next - BPM_MAX - 1).
    - next < BPM_MIN gives BPM_MAX - (BPM_MIN - next - 1).
    - o_at_min and o_at_max still decode the current value.
  - Undefined: saturating clamp as described in Behaviour.

Decomposition:
- tempo_pkg holds:
  - the FSM state encoding (IDLE, HOLD_UP, HOLD_DN, HOLD_BOTH);
  - step constants STEP_SMALL=1 and STEP_LARGE=5;
  - a function computing REPEAT_CYCLES.
- Sub-module repeat_timer: counter, terminal-count tick, synchronous clear, enable. Two instances (up and down) or one instance shared by the FSM; the single shared instance is preferred.

Test Plan:
- Reset release: o_bpm=120, o_bpm_changed=0, o_at_min=0, o_at_max=0.
- Sequence i_plus_1, then i_plus_5, then i_minus_1 on separate cycles -> o_bpm 121, 126, 125, each one cycle after its pulse, with three strobes.
- i_plus_5 and i_minus_1 in the same cycle from 120 -> o_bpm=124 with one strobe. i_plus_1 and i_minus_1 in the same cycle -> no change, no strobe.
- o_bpm=298, then i_plus_5 -> 300 and o_at_max=1. A further i_plus_5 -> stays 300 with no strobe. With TEMPO_WRAP_EN, 298 +5 -> 32.
- REPEAT_MS=1 and CLK_FREQ_HZ=10000 (REPEAT_CYCLES=10): i_minus_5 pulse, then i_minus_5_hold high for 35 cycles from 120 -> values 115, 110, 105, 100, with repeats at cycles 10, 20 and 30 after hold assertion. Raising i_plus_5_hold during this -> repeats stop.
- Soft reset during hold at 200, with i_plus_1 in the same cycle -> o_bpm=120, FSM=IDLE, counter=0. With hold still high, the FSM re-enters HOLD_UP and the first repeat comes a full interval later. Asserting i_reset mid-operation -> immediate BPM_DEFAULT.
